// File: rtl/key_pkg.sv
// Shared types and constants for the pushbutton conditioning path.
package key_pkg;

  typedef enum logic [1:0] {REL, PRESS_CHK, HELD, REL_CHK} key_state_t;

  localparam int DEBOUNCE_SIM     = 4;
  localparam int DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: two-flop synchronizer, consecutive-sample
// debounce FSM, and registered level / press / release pulse outputs.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse
);

  // The counter holds how many agreeing samples have been seen so far; the
  // sample that would make it DEBOUNCE_CYCLES is accepted on the same edge,
  // so pressed rises DEBOUNCE_CYCLES+2 edges after key_n is first sampled.
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  key_state_t       r_state;

  // Two-flop synchronizer; idles at 1 (released) out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM with registered level and single-cycle pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= REL;
      r_cnt           <= '0;
      o_pressed       <= 1'b0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
    end else begin
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      case (r_state)
        REL: begin
          if (!r_sync2) begin
            if (LP_LAST == '0) begin
              // Single-sample qualification accepts immediately.
              r_state       <= HELD;
              r_cnt         <= '0;
              o_pressed     <= 1'b1;
              o_press_pulse <= 1'b1;
            end else begin
              r_state <= PRESS_CHK;
              r_cnt   <= LP_ONE;
            end
          end
        end
        PRESS_CHK: begin
          if (r_sync2) begin
            r_state <= REL;
            r_cnt   <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state       <= HELD;
            r_cnt         <= '0;
            o_pressed     <= 1'b1;
            o_press_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        HELD: begin
          if (r_sync2) begin
            if (LP_LAST == '0) begin
              r_state         <= REL;
              r_cnt           <= '0;
              o_pressed       <= 1'b0;
              o_release_pulse <= 1'b1;
            end else begin
              r_state <= REL_CHK;
              r_cnt   <= LP_ONE;
            end
          end
        end
        REL_CHK: begin
          if (!r_sync2) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state         <= REL;
            r_cnt           <= '0;
            o_pressed       <= 1'b0;
            o_release_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        default: begin
          r_state   <= REL;
          r_cnt     <= '0;
          o_pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Array of independent debounced pushbutton channels.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] pressed,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .i_clk          (Clk),
      .i_rst_n        (Reset),
      .i_key_n        (key_n[g]),
      .o_pressed      (pressed[g]),
      .o_press_pulse  (press_pulse[g]),
      .o_release_pulse(release_pulse[g])
    );
  end

endmodule
